// File: rtl/pi_code_ctrl.sv
// pi_code_ctrl: CDR phase-control loop driving the 11-bit PMIX phase-interpolator code.
// Bang-bang early/late votes are decimated over DECIM valid samples. Each window then
// updates a wrapping phase accumulator through a proportional path, plus a frequency
// (integral) path when PI_FREQ_PATH_EN is defined. Without PI_FREQ_PATH_EN the frequency
// register stays at zero and the loop is first-order.
module pi_code_ctrl #(
  parameter int DECIM    = 8,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 4,
  parameter int FRAC_W   = 8,
  parameter int FREQ_W   = 16,
  parameter int MAX_STEP = 8,
  parameter int LOCK_CNT = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Vote_Valid,
  input  logic                     Early,
  input  logic                     Late,
  input  logic                     Hold,
  output logic [10:0]              Code_Out,
  output logic                     Code_Valid,
  output logic                     Locked,
  output logic signed [FREQ_W-1:0] Freq_Out
);

  localparam int CW  = 11;                    // code width
  localparam int PW  = CW + FRAC_W;           // phase accumulator width
  localparam int WCW = $clog2(DECIM);         // window counter width
  localparam int NW  = $clog2(DECIM) + 2;     // signed net-vote width
  localparam int LW  = $clog2(LOCK_CNT + 1);  // qualifying-run counter width
  localparam int MAXA = (NW + FRAC_W > FREQ_W) ? NW + FRAC_W : FREQ_W;
  localparam int DW  = ((MAXA > PW) ? MAXA : PW) + 2;  // loop-filter arithmetic width

  localparam logic signed [DW-1:0] STEP_LIM  = DW'(MAX_STEP << FRAC_W);
  localparam logic        [NW-1:0] NET_FULL  = NW'(DECIM);
  localparam logic        [NW-1:0] NET_QUIET = NW'(DECIM / 4);

  typedef enum logic {ACQ, TRACK} state_t;

  state_t                    state;
  logic [WCW-1:0]            win_cnt;
  logic signed [NW-1:0]      net;
  logic [PW-1:0]             phase_acc;
  logic signed [FREQ_W-1:0]  freq;
  logic [LW-1:0]             run_cnt;

  logic                      accept;
  logic                      last;
  logic signed [1:0]         vote;
  logic signed [NW-1:0]      net_sum;
  logic        [NW-1:0]      net_abs;
  logic                      qualify;
  logic signed [DW-1:0]      scaled;
  logic signed [DW-1:0]      prop;
  logic signed [DW-1:0]      intg;
  logic signed [DW-1:0]      step_sum;
  logic signed [DW-1:0]      delta;
  logic [PW-1:0]             phase_next;
  logic signed [FREQ_W-1:0]  freq_next;

`ifdef PI_FREQ_PATH_EN
  logic signed [FREQ_W:0]    freq_sum;
`endif

  // Vote decode, window bookkeeping and the loop-filter datapath for the update step.
  // NOTE: every signal driven here gets a default before any branch so no latch is inferred.
  always_comb begin
    accept = Vote_Valid & ~Hold;
    last   = accept && (win_cnt == WCW'(DECIM - 1));

    vote = 2'sd0;
    if (Late && !Early)      vote = 2'sd1;
    else if (Early && !Late) vote = -2'sd1;

    // The final sample of a window is included in the update, so work from net + vote.
    net_sum = net + {{(NW-2){vote[1]}}, vote};
    net_abs = net_sum[NW-1] ? NW'(-net_sum) : NW'(net_sum);
    qualify = (state == TRACK) ? (net_abs == NET_FULL) : (net_abs <= NET_QUIET);

    // Proportional path: gain is one step higher in ACQ for faster pull-in.
    scaled = {{(DW-NW){net_sum[NW-1]}}, net_sum} <<< FRAC_W;
    prop   = (state == TRACK) ? (scaled >>> KP_SHIFT) : (scaled >>> (KP_SHIFT - 1));

    // Integral path uses the registered, pre-update frequency value.
    intg = {{(DW-FREQ_W){freq[FREQ_W-1]}}, freq} >>> KI_SHIFT;

    step_sum = prop + intg;
    delta    = step_sum;
    if (step_sum > STEP_LIM)       delta = STEP_LIM;
    else if (step_sum < -STEP_LIM) delta = -STEP_LIM;

    // Modulo add: the code wraps 2047 <-> 0 seamlessly.
    phase_next = phase_acc + PW'(delta);

`ifdef PI_FREQ_PATH_EN
    freq_sum  = {freq[FREQ_W-1], freq} + {{(FREQ_W+1-NW){net_sum[NW-1]}}, net_sum};
    freq_next = freq_sum[FREQ_W-1:0];
    // Overflow shows as disagreement of the two top bits; pin to the signed rail.
    if (freq_sum[FREQ_W] != freq_sum[FREQ_W-1])
      freq_next = freq_sum[FREQ_W] ? {1'b1, {(FREQ_W-1){1'b0}}} : {1'b0, {(FREQ_W-1){1'b1}}};
`else
    freq_next = '0;
`endif
  end

  // Loop state, ACQ/TRACK FSM and registered outputs; Hold freezes everything.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ACQ;
      win_cnt    <= '0;
      net        <= '0;
      phase_acc  <= '0;
      freq       <= '0;
      run_cnt    <= '0;
      Code_Valid <= 1'b0;
      Locked     <= 1'b0;
    end else begin
      Code_Valid <= 1'b0;
      if (accept) begin
        if (last) begin
          win_cnt    <= '0;
          net        <= '0;
          phase_acc  <= phase_next;
          freq       <= freq_next;
          Code_Valid <= 1'b1;
          if (!qualify) begin
            run_cnt <= '0;
          end else if (run_cnt == LW'(LOCK_CNT - 1)) begin
            run_cnt <= '0;
            if (state == ACQ) begin
              state  <= TRACK;
              Locked <= 1'b1;
            end else begin
              state  <= ACQ;
              Locked <= 1'b0;
            end
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end else begin
          win_cnt <= win_cnt + 1'b1;
          net     <= net_sum;
        end
      end
    end
  end

  // The code is the integer part of the phase accumulator, which only moves on updates.
  assign Code_Out = phase_acc[PW-1 -: CW];
  assign Freq_Out = freq;

endmodule

// File: tb/tb_pi_code_ctrl.sv
// tb_pi_code_ctrl: randomized and directed stimulus for pi_code_ctrl, checked against a
// window-level arithmetic model through an expectation queue drained by a monitor.
module tb_pi_code_ctrl;

  localparam int DECIM    = 8;
  localparam int KP_SHIFT = 2;
  localparam int KI_SHIFT = 4;
  localparam int FRAC_W   = 8;
  localparam int FREQ_W   = 16;
  localparam int MAX_STEP = 8;
  localparam int LOCK_CNT = 16;
  localparam int PHASE_MOD = 1 << (11 + FRAC_W);
  localparam int ONE_CODE  = 1 << FRAC_W;
  localparam int FREQ_MAX  = (1 << (FREQ_W - 1)) - 1;
  localparam int FREQ_MIN  = -(1 << (FREQ_W - 1));

`ifdef PI_FREQ_PATH_EN
  localparam bit FREQ_EN = 1'b1;
`else
  localparam bit FREQ_EN = 1'b0;
`endif

  logic                     CLK = 1'b0;
  logic                     RST;
  logic                     Vote_Valid;
  logic                     Early;
  logic                     Late;
  logic                     Hold;
  logic [10:0]              Code_Out;
  logic                     Code_Valid;
  logic                     Locked;
  logic signed [FREQ_W-1:0] Freq_Out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int code;
    int freq;
    bit locked;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state, at the level of whole windows.
  int m_win[$];
  int m_phase = 0;
  int m_freq  = 0;
  int m_run   = 0;
  bit m_track = 1'b0;

  pi_code_ctrl #(
    .DECIM(DECIM), .KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT), .FRAC_W(FRAC_W),
    .FREQ_W(FREQ_W), .MAX_STEP(MAX_STEP), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .CLK(CLK), .RST(RST), .Vote_Valid(Vote_Valid), .Early(Early), .Late(Late), .Hold(Hold),
    .Code_Out(Code_Out), .Code_Valid(Code_Valid), .Locked(Locked), .Freq_Out(Freq_Out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Floor division, matching an arithmetic right shift on signed values.
  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Model: collect votes until a full window, then apply the loop equations.
  always @(posedge CLK) begin
    int net, g, prop, intg, delta, lim;
    exp_t e;
    bit qual;
    if (RST) begin
      m_win.delete();
      exp_q.delete();
      m_phase = 0; m_freq = 0; m_run = 0; m_track = 1'b0;
    end else if (Vote_Valid && !Hold) begin
      m_win.push_back((Late && !Early) ? 1 : ((Early && !Late) ? -1 : 0));
      if (m_win.size() == DECIM) begin
        net  = m_win.sum();
        g    = m_track ? KP_SHIFT : KP_SHIFT - 1;
        prop = fdiv(net * ONE_CODE, 1 << g);
        intg = FREQ_EN ? fdiv(m_freq, 1 << KI_SHIFT) : 0;
        lim  = MAX_STEP * ONE_CODE;
        delta = prop + intg;
        if (delta > lim)  delta = lim;
        if (delta < -lim) delta = -lim;
        m_phase = (m_phase + delta) % PHASE_MOD;
        if (m_phase < 0) m_phase = m_phase + PHASE_MOD;
        if (FREQ_EN) begin
          m_freq = m_freq + net;
          if (m_freq > FREQ_MAX) m_freq = FREQ_MAX;
          if (m_freq < FREQ_MIN) m_freq = FREQ_MIN;
        end
        qual = m_track ? (iabs(net) == DECIM) : (iabs(net) <= DECIM / 4);
        m_run = qual ? m_run + 1 : 0;
        if (m_run == LOCK_CNT) begin
          m_track = !m_track;
          m_run = 0;
        end
        e.code = m_phase / ONE_CODE;
        e.freq = m_freq;
        e.locked = m_track;
        exp_q.push_back(e);
        m_win.delete();
      end
    end
  end

  // Monitor: away from the active edge, either consume the expected update or
  // confirm that nothing moved.
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("code_valid_pulse", int'(Code_Valid), 1);
      check("code_out", int'(Code_Out), e.code);
      check("freq_out", int'($signed(Freq_Out)), e.freq);
      check("locked", int'(Locked), int'(e.locked));
    end else begin
      check("code_valid_idle", int'(Code_Valid), 0);
      check("code_stable", int'(Code_Out), m_phase / ONE_CODE);
      check("freq_stable", int'($signed(Freq_Out)), m_freq);
      check("locked_stable", int'(Locked), int'(m_track));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input bit r, input bit vv, input bit e, input bit l, input bit h);
    RST = r; Vote_Valid = vv; Early = e; Late = l; Hold = h;
    @(posedge CLK);
    #1;
  endtask

  task automatic sample(input bit e, input bit l);
    cyc(1'b0, 1'b1, e, l, 1'b0);
  endtask

  task automatic late_window();
    for (int i = 0; i < DECIM; i++) sample(1'b0, 1'b1);
  endtask

  int code_before;

  initial begin
    // Reset while random votes are driven.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check("rst_code", int'(Code_Out), 0);
      check("rst_valid", int'(Code_Valid), 0);
      check("rst_locked", int'(Locked), 0);
      check("rst_freq", int'($signed(Freq_Out)), 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Acquisition step down: 8 Early-only samples from reset.
    for (int i = 0; i < DECIM; i++) begin
      sample(1'b1, 1'b0);
      if (i < DECIM - 1) check("no_early_update", int'(Code_Valid), 0);
    end
    check("acq_step_down", int'(Code_Out), 2044);
    check("step_pulse", int'(Code_Valid), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pulse_one_cycle", int'(Code_Valid), 0);

    // Upward wrap: half-late window, then a full late window crosses 2047 -> 0.
    for (int i = 0; i < DECIM; i++) sample(1'b0, i < DECIM / 2);
    late_window();
    check("upward_wrap", int'(Code_Out), FREQ_EN ? 1 : 2);

    // Lock entry with net=0 windows, then lock loss with all-late windows.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < LOCK_CNT; w++) begin
      for (int i = 0; i < DECIM; i++) sample(i[0], !i[0]);
      if (w == LOCK_CNT - 2) check("not_yet_locked", int'(Locked), 0);
    end
    check("lock_entry", int'(Locked), 1);
    code_before = int'(Code_Out);
    late_window();
    check("track_step_2", (int'(Code_Out) - code_before + 2048) % 2048, 2);
    for (int w = 1; w < LOCK_CNT; w++) begin
      late_window();
      if (w == LOCK_CNT - 2) check("still_locked", int'(Locked), 1);
    end
    check("lock_loss", int'(Locked), 0);
    check("freq_after_track", int'($signed(Freq_Out)), FREQ_EN ? 8 * LOCK_CNT : 0);

    // Hold after 5 samples, then 3 more samples finish the window.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sample(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    sample(1'b0, 1'b1);
    sample(1'b0, 1'b1);
    check("hold_no_early_update", int'(Code_Valid), 0);
    sample(1'b0, 1'b1);
    check("hold_resume_update", int'(Code_Valid), 1);
    check("hold_resume_code", int'(Code_Out), 4);

    // Mid-window reset discards the partial window.
    for (int i = 0; i < 5; i++) sample(1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DECIM; i++) begin
      sample(1'b1, 1'b0);
      if (i == DECIM - 2) check("rst_window_discarded", int'(Code_Valid), 0);
    end
    check("rst_full_window", int'(Code_Valid), 1);
    check("rst_window_code", int'(Code_Out), 2044);

    // Sustained late windows drive the frequency register to its positive rail.
    for (int w = 0; w < 4200; w++) late_window();
    check("freq_saturate", int'($signed(Freq_Out)), FREQ_EN ? FREQ_MAX : 0);

    // Randomized traffic in segments with different vote bias.
    for (int s = 0; s < 15; s++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 200; i++) begin
        bit e, l;
        e = (mode == 1) ? ($urandom % 8 != 0) : 1'($urandom);
        l = (mode == 2) ? ($urandom % 8 != 0) : 1'($urandom);
        cyc($urandom % 1000 == 0, $urandom % 4 != 0, e, l, $urandom % 16 == 0);
      end
    end

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
